// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bit sequencer: command and state encodings
// plus the per-phase SCL/SDA waveform table.
package i2c_pkg;

   typedef enum logic [1:0] {
      CMD_START = 2'b00,
      CMD_STOP  = 2'b01,
      CMD_WRITE = 2'b10,
      CMD_READ  = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_PH0,
      ST_PH1,
      ST_PH2,
      ST_PH3
   } state_e;

   // Returns {scl, sda} open-drain levels (1 = released) for one bit phase.
   function automatic logic [1:0] phase_wave(cmd_e cmd, logic [1:0] phase, logic d);
      logic scl;
      logic sda;
      scl = (phase == 2'd1) || (phase == 2'd2);
      sda = 1'b1;
      case (cmd)
         CMD_START: begin
            scl = (phase != 2'd3);
            sda = (phase == 2'd0);
         end
         CMD_STOP: begin
            scl = (phase != 2'd0);
            sda = (phase == 2'd3);
         end
         CMD_WRITE: sda = d;
         default:   sda = 1'b1;
      endcase
      return {scl, sda};
   endfunction

endpackage

// File: rtl/i2c_bit_ctrl.sv
// Tick-paced I2C bit sequencer: START/STOP/WRITE/READ as four phases each.
// Optional clock stretching in the high phase via macro I2C_CLK_STRETCH_EN.
module i2c_bit_ctrl
   import i2c_pkg::*;
#(
   parameter int SAMPLE_PHASE = 1
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic [1:0] Cmd,
   input  logic       Din,
   input  logic       Cmd_valid,
   output logic       Cmd_ready,
   output logic       Done,
   output logic       Dout,
   input  logic       Tick,
   output logic       Timer_start,
   output logic       Timer_stop,
   input  logic       Sda_i,
`ifdef I2C_CLK_STRETCH_EN
   input  logic       Scl_i,
`endif
   output logic       Scl_o,
   output logic       Sda_o
);

   localparam state_e SAMPLE_ST = (SAMPLE_PHASE == 2) ? ST_PH2 : ST_PH1;

   state_e     state_q, state_d;
   cmd_e       cmd_q;
   logic       din_q;
   logic       accept;
   logic       hold_start;
   logic       enter_ph;
   logic [1:0] phase_d;
`ifdef I2C_CLK_STRETCH_EN
   logic       stretch_q, stretch_d;
`endif

   assign Cmd_ready   = (state_q == ST_IDLE);
   assign Timer_stop  = (state_q == ST_IDLE);
   assign Timer_start = Rst_n & (accept | hold_start);

   // NOTE: every always_comb target gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      hold_start = 1'b0;
      enter_ph   = 1'b0;
      phase_d    = 2'd0;
`ifdef I2C_CLK_STRETCH_EN
      stretch_d  = stretch_q;
`endif
      case (state_q)
         ST_IDLE: if (Cmd_valid) begin
            accept  = 1'b1;
            state_d = ST_SYNC;
         end
         ST_SYNC: if (Tick) begin
            state_d  = ST_PH0;
            enter_ph = 1'b1;
            phase_d  = 2'd0;
         end
         ST_PH0: if (Tick) begin
            state_d  = ST_PH1;
            enter_ph = 1'b1;
            phase_d  = 2'd1;
         end
         ST_PH1: begin
`ifdef I2C_CLK_STRETCH_EN
            // A slave holding SCL low keeps reloading the timer; the first tick
            // after release only re-synchronises the phase to the real SCL edge.
            if (!Scl_i) begin
               stretch_d  = 1'b1;
               hold_start = 1'b1;
            end else if (Tick) begin
               if (stretch_q) begin
                  stretch_d = 1'b0;
               end else begin
                  state_d  = ST_PH2;
                  enter_ph = 1'b1;
                  phase_d  = 2'd2;
               end
            end
`else
            if (Tick) begin
               state_d  = ST_PH2;
               enter_ph = 1'b1;
               phase_d  = 2'd2;
            end
`endif
         end
         ST_PH2: if (Tick) begin
            state_d  = ST_PH3;
            enter_ph = 1'b1;
            phase_d  = 2'd3;
         end
         ST_PH3: if (Tick) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state and outputs use non-blocking assignments so every register
   // sees the pre-edge values of the others.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q   <= ST_IDLE;
         cmd_q     <= CMD_START;
         din_q     <= 1'b0;
         Scl_o     <= 1'b1;
         Sda_o     <= 1'b1;
         Done      <= 1'b0;
         Dout      <= 1'b0;
`ifdef I2C_CLK_STRETCH_EN
         stretch_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         Done    <= (state_q == ST_PH3) && Tick;
`ifdef I2C_CLK_STRETCH_EN
         stretch_q <= stretch_d;
`endif
         if (accept) begin
            cmd_q <= cmd_e'(Cmd);
            din_q <= Din;
         end
         if (enter_ph) {Scl_o, Sda_o} <= phase_wave(cmd_q, phase_d, din_q);
         // Sample only on the tick that actually closes the sample phase.
         if (cmd_q == CMD_READ && state_q == SAMPLE_ST && state_d != state_q)
            Dout <= Sda_i;
      end
   end

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Self-checking bench for i2c_bit_ctrl with a behavioural bit timer (Ticks=3).
// Stretch sequence is compiled in when I2C_CLK_STRETCH_EN is defined.
module tb_i2c_bit_ctrl;
   import i2c_pkg::*;

   localparam int TICKS = 3;
   localparam int SP    = 1;
   localparam int SK    = 5 + 4 * SP;  // cycle after acceptance whose edge samples Sda_i

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic [1:0] Cmd = 2'b00;
   logic       Din = 1'b0;
   logic       Cmd_valid = 1'b0;
   logic       Cmd_ready, Done, Dout, Tick, Timer_start, Timer_stop;
   logic       Sda_i = 1'b1;
   logic       Scl_o, Sda_o;
`ifdef I2C_CLK_STRETCH_EN
   logic       Scl_i = 1'b1;
`endif

   logic timer_tick = 1'b0;
   logic tick_inj = 1'b0;
   int   tcnt = 0;

   int n_checks = 0;
   int n_pass = 0;

   logic exp_scl = 1'b1;
   logic exp_sda = 1'b1;
   logic exp_dout = 1'b0;

   typedef struct {
      logic [1:0] cmd;
      logic       din;
      int         mode;
      logic [3:0] escl;
      logic [3:0] esda;
      logic       edout;
   } vec_t;

   vec_t tbl[7];

   assign Tick = timer_tick | tick_inj;

   always #5 Clk = ~Clk;

   i2c_bit_ctrl #(.SAMPLE_PHASE(SP)) dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .Cmd        (Cmd),
      .Din        (Din),
      .Cmd_valid  (Cmd_valid),
      .Cmd_ready  (Cmd_ready),
      .Done       (Done),
      .Dout       (Dout),
      .Tick       (Tick),
      .Timer_start(Timer_start),
      .Timer_stop (Timer_stop),
      .Sda_i      (Sda_i),
`ifdef I2C_CLK_STRETCH_EN
      .Scl_i      (Scl_i),
`endif
      .Scl_o      (Scl_o),
      .Sda_o      (Sda_o)
   );

   // Bit timer: reload answers with a tick next cycle, then one every TICKS+1 clocks.
   always @(posedge Clk) begin
      if (!Rst_n) begin
         timer_tick <= 1'b0;
         tcnt       <= 0;
      end else if (Timer_start) begin
         timer_tick <= 1'b1;
         tcnt       <= 0;
      end else if (!Timer_stop) begin
         if (tcnt == TICKS) begin
            timer_tick <= 1'b1;
            tcnt       <= 0;
         end else begin
            timer_tick <= 1'b0;
            tcnt       <= tcnt + 1;
         end
      end else begin
         timer_tick <= 1'b0;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, required %b", name, act, exp);
   endtask

   function automatic logic [6:0] outs();
      return {Cmd_ready, Done, Dout, Scl_o, Sda_o, Timer_stop, Timer_start};
   endfunction

   function automatic logic drive_sda(input int mode, input int k);
      case (mode)
         0:       return 1'b1;
         1:       return (k == SK) ? 1'b0 : 1'b1;
         default: return 1'($urandom);
      endcase
   endfunction

   // Whole-bit bus picture, phase 0 in the MSB.
   task automatic ref_wave(input logic [1:0] c, input logic d,
                           output logic [3:0] escl, output logic [3:0] esda);
      case (c)
         CMD_START: begin escl = 4'b1110; esda = 4'b1000; end
         CMD_STOP:  begin escl = 4'b0111; esda = 4'b0001; end
         CMD_WRITE: begin escl = 4'b0110; esda = {4{d}};  end
         default:   begin escl = 4'b0110; esda = 4'b1111; end
      endcase
   endtask

   // One complete bit from acceptance (cycle 0) to the Done cycle (cycle 18).
   task automatic run_bit(input logic [1:0] c, input logic d, input logic [3:0] escl,
                          input logic [3:0] esda, input int mode, input bit noise,
                          input string tag);
      logic smp;
      int   ph;
      smp = exp_dout;
      @(posedge Clk); #1;
      Cmd = c; Din = d; Cmd_valid = 1'b1;
      Sda_i = drive_sda(mode, 0);
      tick_inj = noise & 1'($urandom);
      @(negedge Clk);
      check({tag, " accept"}, outs(), {1'b1, 1'b0, exp_dout, exp_scl, exp_sda, 1'b1, 1'b1});
      for (int k = 1; k <= 18; k++) begin
         @(posedge Clk); #1;
         tick_inj  = 1'b0;
         Cmd_valid = noise && (k < 18) && 1'($urandom);
         Cmd       = 2'($urandom);
         Din       = 1'($urandom);
         Sda_i     = drive_sda(mode, k);
         if (k == SK) smp = Sda_i;
         if (k >= 2 && k <= 17) begin
            ph      = (k - 2) / 4;
            exp_scl = escl[3 - ph];
            exp_sda = esda[3 - ph];
         end
         if (c == CMD_READ && k == SK + 1) exp_dout = smp;
         @(negedge Clk);
         check($sformatf("%s cyc%0d", tag, k), outs(),
               {k == 18, k == 18, exp_dout, exp_scl, exp_sda, k == 18, 1'b0});
      end
   endtask

   task automatic idle(input int n, input bit noise);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk); #1;
         Cmd_valid = 1'b0;
         tick_inj  = noise & 1'($urandom);
         Sda_i     = 1'($urandom);
         @(negedge Clk);
         check("idle hold", outs(), {1'b1, 1'b0, exp_dout, exp_scl, exp_sda, 1'b1, 1'b0});
      end
   endtask

   initial begin
      logic [1:0] rc;
      logic       rd;
      logic [3:0] escl, esda;

      tbl[0] = '{CMD_START, 1'b0, 0, 4'b1110, 4'b1000, 1'b0};
      tbl[1] = '{CMD_WRITE, 1'b0, 0, 4'b0110, 4'b0000, 1'b0};
      tbl[2] = '{CMD_WRITE, 1'b1, 0, 4'b0110, 4'b1111, 1'b0};
      tbl[3] = '{CMD_READ,  1'b0, 0, 4'b0110, 4'b1111, 1'b1};
      tbl[4] = '{CMD_READ,  1'b1, 1, 4'b0110, 4'b1111, 1'b0};
      tbl[5] = '{CMD_WRITE, 1'b0, 0, 4'b0110, 4'b0000, 1'b0};
      tbl[6] = '{CMD_STOP,  1'b1, 0, 4'b0111, 4'b0001, 1'b0};

      repeat (2) @(posedge Clk);
      #1;
      @(negedge Clk);
      check("reset state", outs(), 7'b1_0_0_1_1_1_0);
      @(posedge Clk); #1;
      Rst_n = 1'b1;
      @(negedge Clk);
      check("first idle", outs(), 7'b1_0_0_1_1_1_0);

      // Directed table, issued back-to-back.
      for (int i = 0; i < 7; i++) begin
         run_bit(tbl[i].cmd, tbl[i].din, tbl[i].escl, tbl[i].esda, tbl[i].mode, 1'b0,
                 $sformatf("tbl%0d", i));
         if (tbl[i].cmd == CMD_READ)
            check($sformatf("tbl%0d dout", i), {6'd0, Dout}, {6'd0, tbl[i].edout});
      end
      idle(3, 1'b1);

      // Reset during PH2 of a READ that would otherwise leave Dout set.
      run_bit(CMD_READ, 1'b0, 4'b0110, 4'b1111, 0, 1'b0, "pre-rst read");
      @(posedge Clk); #1;
      Cmd = CMD_READ; Cmd_valid = 1'b1; tick_inj = 1'b0; Sda_i = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge Clk); #1;
         Cmd_valid = 1'b0;
         Rst_n = (k == 11) ? 1'b0 : 1'b1;
         @(negedge Clk);
         if (k == 10) check("mid-read scl high", {6'd0, Scl_o}, 7'd1);
         if (k == 12) check("reset mid-read", outs(), 7'b1_0_0_1_1_1_0);
      end
      exp_scl = 1'b1; exp_sda = 1'b1; exp_dout = 1'b0;
      idle(4, 1'b0);

      // Randomised commands, noise on Tick/Cmd_valid/Sda_i, gaps 0..2 idle cycles.
      for (int i = 0; i < 40; i++) begin
         rc = 2'($urandom);
         rd = 1'($urandom);
         ref_wave(rc, rd, escl, esda);
         run_bit(rc, rd, escl, esda, 2, 1'b1, $sformatf("rnd%0d", i));
         idle($urandom_range(0, 2), 1'b1);
      end

`ifdef I2C_CLK_STRETCH_EN
      // Slave holds SCL low for 10 clocks inside PH1 of a WRITE.
      @(posedge Clk); #1;
      Cmd = CMD_WRITE; Din = 1'b1; Cmd_valid = 1'b1; tick_inj = 1'b0; Scl_i = 1'b1;
      @(negedge Clk);
      check("stretch accept", {6'd0, Timer_start}, 7'd1);
      for (int k = 1; k <= 30; k++) begin
         @(posedge Clk); #1;
         Cmd_valid = 1'b0;
         Scl_i = !(k >= 7 && k <= 16);
         @(negedge Clk);
         check($sformatf("stretch done cyc%0d", k), {6'd0, Done}, {6'd0, k == 30});
         if (k >= 7 && k <= 16)
            check($sformatf("stretch hold cyc%0d", k), {5'd0, Timer_start, Scl_o}, 7'b11);
         if (k == 25) check("stretch ph2 scl", {6'd0, Scl_o}, 7'd1);
         if (k == 26) check("stretch ph3 scl", {6'd0, Scl_o}, 7'd0);
      end
      exp_scl = 1'b0; exp_sda = 1'b1;
      idle(2, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
